uart_rx_fifo_apb: RTL and testbench

//  Downstream stage of the UART receiver. Captures each byte the RX controller delivers as a
//  1-cycle strobe + 8-bit data into a circular FIFO. Exposes the FIFO to the CPU as an APB3

---
 rtl/uart_apb_pkg.sv | 40 ++++
 rtl/uart_rx_fifo_mem.sv | 59 +++++
 rtl/uart_rx_fifo_apb.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo_apb.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Register map, bit positions and shared constants for the UART APB register blocks.
// Also used by the TX-side APB block, so keep offsets stable.
package uart_apb_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_THRESH_LSB = 0;
    localparam int CTRL_RXIE       = 16;
    localparam int CTRL_OVIE       = 17;
    localparam int CTRL_FLUSH      = 24;

    localparam int THRESH_RESET = 1;

    typedef enum logic [1:0] {
        RegData,
        RegStatus,
        RegCtrl,
        RegNone
    } regSelT;

    // Only address bits [3:2] select a register; [1:0] are ignored.
    function automatic regSelT decodeReg(input logic [3:0] addr);
        logic [3:0] base;
        base = {addr[3:2], 2'b00};
        if (base == REG_DATA)        return RegData;
        else if (base == REG_STATUS) return RegStatus;
        else if (base == REG_CTRL)   return RegCtrl;
        else                         return RegNone;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Circular receive FIFO: storage array, ADDR_W+1 bit wrap pointers, full/empty/count.
// status is packed as {count, full, empty}.
module uart_rx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W+2:0] status
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wrPtr;
    logic [ADDR_W:0]   rdPtr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              doPush;
    logic              doPop;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) &&
                   (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);
    assign count = wrPtr - rdPtr;

    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // is accepted when accompanied by a pop. Flush discards any push.
    assign doPop  = pop & ~empty;
    assign doPush = push & ~flush & (~full | doPop);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[ADDR_W-1:0]] <= wdata;
    end

    assign rdata  = empty ? '0 : mem[rdPtr[ADDR_W-1:0]];
    assign status = {count, full, empty};

endmodule

// File: rtl/uart_rx_fifo_apb.sv
// UART RX FIFO with APB3 register interface (DATA / STATUS / CTRL) and overrun detection.
// Optional interrupt logic and CTRL THRESH/RXIE/OVIE fields under `UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo_apb #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = uart_apb_pkg::DATA_W
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iRX_VALID,
    input  logic [DATA_W-1:0] iRX_DATA,
    input  logic              iPSEL,
    input  logic              iPENABLE,
    input  logic              iPWRITE,
    input  logic [3:0]        iPADDR,
    input  logic [31:0]       iPWDATA,
    output logic [31:0]       oPRDATA,
    output logic              oPREADY,
    output logic              oPSLVERR,
    output logic              oIRQ
);

    import uart_apb_pkg::*;

    // Handshakes: iRX_VALID is a single-cycle strobe with no backpressure (a byte
    // arriving while full is dropped and flagged). APB completes every access on
    // the rising edge where iPSEL & iPENABLE are high; oPREADY is always 1.

    regSelT            regSel;
    logic              apbAccess;
    logic              apbRd;
    logic              popReq;
    logic              statusWr;
    logic              ctrlWr;
    logic              flush;
    logic              overrun;
    logic              overrunSet;
    logic [DATA_W-1:0] fifoRdata;
    logic [ADDR_W+2:0] fifoStatus;
    logic [ADDR_W:0]   fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [31:0]       statusWord;
    logic [31:0]       ctrlWord;
    logic [31:0]       readData;
    logic              unusedBits;

    assign regSel    = decodeReg(iPADDR);
    assign apbAccess = iPSEL & iPENABLE;
    assign apbRd     = apbAccess & ~iPWRITE;
    assign popReq    = apbRd & (regSel == RegData);
    assign statusWr  = apbAccess & iPWRITE & (regSel == RegStatus);
    assign ctrlWr    = apbAccess & iPWRITE & (regSel == RegCtrl);
    assign flush     = ctrlWr & iPWDATA[CTRL_FLUSH];

    assign {fifoCount, fifoFull, fifoEmpty} = fifoStatus;

    uart_rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uFifo (
        .clk    (iCLK),
        .rstN   (iRESETn),
        .push   (iRX_VALID),
        .pop    (popReq),
        .flush  (flush),
        .wdata  (iRX_DATA),
        .rdata  (fifoRdata),
        .status (fifoStatus)
    );

    // A full FIFO with a concurrent pop accepts the byte, so that is not an overrun.
    assign overrunSet = iRX_VALID & fifoFull & ~popReq;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            overrun <= 1'b0;
        end else if (overrunSet) begin
            overrun <= 1'b1;
        end else if (statusWr && iPWDATA[STAT_OVERRUN]) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_IRQ_EN
    logic [ADDR_W:0] thresh;
    logic            rxIe;
    logic            ovIe;
    logic            irqNext;

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            thresh <= (ADDR_W+1)'(THRESH_RESET);
            rxIe   <= 1'b0;
            ovIe   <= 1'b0;
        end else if (ctrlWr) begin
            thresh <= iPWDATA[CTRL_THRESH_LSB +: ADDR_W+1];
            rxIe   <= iPWDATA[CTRL_RXIE];
            ovIe   <= iPWDATA[CTRL_OVIE];
        end
    end

    assign irqNext = (rxIe & (fifoCount >= thresh) & ~fifoEmpty) | (ovIe & overrun);

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) oIRQ <= 1'b0;
        else          oIRQ <= irqNext;
    end

    always_comb begin
        ctrlWord = '0;
        ctrlWord[CTRL_THRESH_LSB +: ADDR_W+1] = thresh;
        ctrlWord[CTRL_RXIE] = rxIe;
        ctrlWord[CTRL_OVIE] = ovIe;
    end
`else
    assign oIRQ     = 1'b0;
    assign ctrlWord = '0;
`endif

    always_comb begin
        statusWord = '0;
        statusWord[STAT_EMPTY]   = fifoEmpty;
        statusWord[STAT_FULL]    = fifoFull;
        statusWord[STAT_OVERRUN] = overrun;
        statusWord[STAT_COUNT_LSB +: ADDR_W+1] = fifoCount;
    end

    always_comb begin
        readData = '0;
        case (regSel)
            RegData:   readData = {{(32-DATA_W){1'b0}}, fifoRdata};
            RegStatus: readData = statusWord;
            RegCtrl:   readData = ctrlWord;
            default:   readData = '0;
        endcase
    end

    assign oPRDATA  = apbRd ? readData : '0;
    assign oPREADY  = 1'b1;
    assign oPSLVERR = apbAccess & (regSel == RegNone);

    // Byte-lane bits of the address and unmapped write-data bits are intentionally ignored.
    assign unusedBits = ^{iPADDR[1:0], iPWDATA};

endmodule

// File: tb/tb_uart_rx_fifo_apb.sv
// Self-checking bench for uart_rx_fifo_apb; scoreboard queue holds bytes expected from DATA.
// Build with or without `UART_RX_FIFO_IRQ_EN; expectations follow the macro.
module tb_uart_rx_fifo_apb;

    localparam int DEPTH = 16;
    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_BAD    = 4'hC;
`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [31:0] CTRL_RST = 32'h0000_0001;
`else
    localparam logic [31:0] CTRL_RST = 32'h0000_0000;
`endif

    logic        iCLK = 1'b0;
    logic        iRESETn;
    logic        iRX_VALID;
    logic [7:0]  iRX_DATA;
    logic        iPSEL;
    logic        iPENABLE;
    logic        iPWRITE;
    logic [3:0]  iPADDR;
    logic [31:0] iPWDATA;
    logic [31:0] oPRDATA;
    logic        oPREADY;
    logic        oPSLVERR;
    logic        oIRQ;

    int nChecks = 0;
    int nFails  = 0;
    logic [7:0] expQ[$];

    uart_rx_fifo_apb #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .iCLK      (iCLK),
        .iRESETn   (iRESETn),
        .iRX_VALID (iRX_VALID),
        .iRX_DATA  (iRX_DATA),
        .iPSEL     (iPSEL),
        .iPENABLE  (iPENABLE),
        .iPWRITE   (iPWRITE),
        .iPADDR    (iPADDR),
        .iPWDATA   (iPWDATA),
        .oPRDATA   (oPRDATA),
        .oPREADY   (oPREADY),
        .oPSLVERR  (oPSLVERR),
        .oIRQ      (oIRQ)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic rxByte(input logic [7:0] b);
        @(negedge iCLK);
        iRX_VALID = 1'b1;
        iRX_DATA  = b;
        if (expQ.size() < DEPTH) expQ.push_back(b);
        @(negedge iCLK);
        iRX_VALID = 1'b0;
        iRX_DATA  = 8'h00;
    endtask

    task automatic apbRead(input logic [3:0] addr, input logic rxEn, input logic [7:0] rxD,
                           output logic [31:0] rd, output logic err);
        @(negedge iCLK);
        iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b0; iPADDR = addr;
        @(negedge iCLK);
        iPENABLE = 1'b1;
        iRX_VALID = rxEn; iRX_DATA = rxD;
        #1;
        rd  = oPRDATA;
        err = oPSLVERR;
        @(negedge iCLK);
        iPSEL = 1'b0; iPENABLE = 1'b0; iRX_VALID = 1'b0; iRX_DATA = 8'h00;
    endtask

    task automatic apbWrite(input logic [3:0] addr, input logic [31:0] data, input logic rxEn,
                            input logic [7:0] rxD, output logic err);
        @(negedge iCLK);
        iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b1; iPADDR = addr; iPWDATA = data;
        @(negedge iCLK);
        iPENABLE = 1'b1;
        iRX_VALID = rxEn; iRX_DATA = rxD;
        #1;
        err = oPSLVERR;
        @(negedge iCLK);
        iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0;
        iRX_VALID = 1'b0; iRX_DATA = 8'h00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic err;
        iRESETn = 1'b0; iRX_VALID = 1'b0; iRX_DATA = '0;
        iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0; iPADDR = '0; iPWDATA = '0;
        repeat (3) @(negedge iCLK);
        nChecks++;
        if (oPRDATA !== 32'h0 || oIRQ !== 1'b0 || oPREADY !== 1'b1) begin
            nFails++;
            $display("FAIL reset_outputs: prdata=%h irq=%b pready=%b, expected 0/0/1", oPRDATA, oIRQ, oPREADY);
        end
        iRESETn = 1'b1;
        expQ.delete();
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h1) begin
            nFails++; $display("FAIL reset_status: got %h expected %h", rd, 32'h1);
        end
        apbRead(A_CTRL, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== CTRL_RST) begin
            nFails++; $display("FAIL reset_ctrl: got %h expected %h", rd, CTRL_RST);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic [7:0] exp;
        logic err;
        rxByte(8'h41); rxByte(8'h42); rxByte(8'h43);
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h0000_0300) begin
            nFails++; $display("FAIL basic_status3: got %h expected %h", rd, 32'h300);
        end
        for (int i = 0; i < 3; i++) begin
            apbRead(A_DATA, 1'b0, 8'h00, rd, err);
            exp = expQ.pop_front();
            nChecks++;
            if (rd !== {24'h0, exp}) begin
                nFails++; $display("FAIL basic_data[%0d]: got %h expected %h", i, rd, exp);
            end
        end
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h1) begin
            nFails++; $display("FAIL basic_empty: got %h expected %h", rd, 32'h1);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        logic [7:0] exp;
        logic err;
        for (int i = 0; i <= DEPTH; i++) rxByte(8'(i));
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h0000_1006) begin
            nFails++; $display("FAIL ovr_status_full: got %h expected %h", rd, 32'h1006);
        end
        for (int i = 0; i < DEPTH; i++) begin
            apbRead(A_DATA, 1'b0, 8'h00, rd, err);
            exp = expQ.pop_front();
            nChecks++;
            if (rd !== {24'h0, exp}) begin
                nFails++; $display("FAIL ovr_data[%0d]: got %h expected %h", i, rd, exp);
            end
        end
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h5) begin
            nFails++; $display("FAIL ovr_sticky: got %h expected %h", rd, 32'h5);
        end
        apbWrite(A_STATUS, 32'h4, 1'b0, 8'h00, err);
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h1) begin
            nFails++; $display("FAIL ovr_w1c: got %h expected %h", rd, 32'h1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0] exp;
        logic err;
        for (int i = 0; i < DEPTH; i++) rxByte(8'h20 + 8'(i));
        apbRead(A_DATA, 1'b1, 8'h55, rd, err);
        exp = expQ.pop_front();
        expQ.push_back(8'h55);
        nChecks++;
        if (rd !== {24'h0, exp}) begin
            nFails++; $display("FAIL b2b_head: got %h expected %h", rd, exp);
        end
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h0000_1002) begin
            nFails++; $display("FAIL b2b_status: got %h expected %h", rd, 32'h1002);
        end
        for (int i = 0; i < DEPTH; i++) begin
            apbRead(A_DATA, 1'b0, 8'h00, rd, err);
            exp = expQ.pop_front();
            nChecks++;
            if (rd !== {24'h0, exp}) begin
                nFails++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        logic err;
        for (int i = 0; i < DEPTH; i++) rxByte(8'(32'($urandom_range(0, 255))));
        apbWrite(A_STATUS, 32'h4, 1'b1, 8'h77, err);
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h0000_1006) begin
            nFails++; $display("FAIL w1c_set_wins: got %h expected %h", rd, 32'h1006);
        end
        apbWrite(A_STATUS, 32'h4, 1'b0, 8'h00, err);
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h0000_1002) begin
            nFails++; $display("FAIL w1c_clear: got %h expected %h", rd, 32'h1002);
        end
        apbWrite(A_CTRL, 32'h0100_0001, 1'b0, 8'h00, err);
        expQ.delete();
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic [7:0] exp;
        logic err;
        apbWrite(A_CTRL, 32'h0001_0004, 1'b0, 8'h00, err);
        apbRead(A_CTRL, 1'b0, 8'h00, rd, err);
`ifdef UART_RX_FIFO_IRQ_EN
        nChecks++;
        if (rd !== 32'h0001_0004) begin
            nFails++; $display("FAIL irq_ctrl_rb: got %h expected %h", rd, 32'h10004);
        end
        rxByte(8'hA0); rxByte(8'hA1); rxByte(8'hA2);
        @(negedge iCLK);
        nChecks++;
        if (oIRQ !== 1'b0) begin
            nFails++; $display("FAIL irq_below_thresh: got %b expected 0", oIRQ);
        end
        rxByte(8'hA3);
        nChecks++;
        if (oIRQ !== 1'b0) begin
            nFails++; $display("FAIL irq_latency: got %b expected 0", oIRQ);
        end
        @(negedge iCLK);
        nChecks++;
        if (oIRQ !== 1'b1) begin
            nFails++; $display("FAIL irq_at_thresh: got %b expected 1", oIRQ);
        end
        apbRead(A_DATA, 1'b0, 8'h00, rd, err);
        exp = expQ.pop_front();
        nChecks++;
        if (rd !== {24'h0, exp}) begin
            nFails++; $display("FAIL irq_data: got %h expected %h", rd, exp);
        end
        @(negedge iCLK);
        nChecks++;
        if (oIRQ !== 1'b0) begin
            nFails++; $display("FAIL irq_after_pop: got %b expected 0", oIRQ);
        end
`else
        nChecks++;
        if (rd !== 32'h0) begin
            nFails++; $display("FAIL irq_ctrl_rb: got %h expected %h", rd, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            rxByte(8'hA0 + 8'(i));
            nChecks++;
            if (oIRQ !== 1'b0) begin
                nFails++; $display("FAIL irq_tied[%0d]: got %b expected 0", i, oIRQ);
            end
        end
`endif
        apbWrite(A_CTRL, 32'h0100_0001, 1'b0, 8'h00, err);
        expQ.delete();
    endtask

    task automatic test_flush_errors();
        logic [31:0] rd;
        logic err;
        for (int i = 0; i < 5; i++) rxByte(8'hC0 + 8'(i));
        apbWrite(A_CTRL, 32'h0100_0001, 1'b1, 8'h99, err);
        expQ.delete();
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h1) begin
            nFails++; $display("FAIL flush_status: got %h expected %h", rd, 32'h1);
        end
        apbRead(A_DATA, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            nFails++; $display("FAIL empty_read: got data=%h err=%b expected 0/0", rd, err);
        end
        apbRead(A_BAD, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            nFails++; $display("FAIL slverr_read: got err=%b data=%h expected 1/0", err, rd);
        end
        apbWrite(A_BAD, 32'hFFFF_FFFF, 1'b0, 8'h00, err);
        nChecks++;
        if (err !== 1'b1) begin
            nFails++; $display("FAIL slverr_write: got %b expected 1", err);
        end
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (err !== 1'b0) begin
            nFails++; $display("FAIL slverr_valid: got %b expected 0", err);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic err;
        apbWrite(A_CTRL, 32'h0003_0004, 1'b0, 8'h00, err);
        for (int i = 0; i <= DEPTH; i++) rxByte(8'hE0 + 8'(i));
        @(negedge iCLK);
        #2 iRESETn = 1'b0;
        #1;
        nChecks++;
        if (oIRQ !== 1'b0 || oPRDATA !== 32'h0) begin
            nFails++; $display("FAIL async_reset: irq=%b prdata=%h expected 0/0", oIRQ, oPRDATA);
        end
        @(negedge iCLK);
        iRESETn = 1'b1;
        expQ.delete();
        apbRead(A_STATUS, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== 32'h1) begin
            nFails++; $display("FAIL midreset_status: got %h expected %h", rd, 32'h1);
        end
        apbRead(A_CTRL, 1'b0, 8'h00, rd, err);
        nChecks++;
        if (rd !== CTRL_RST) begin
            nFails++; $display("FAIL midreset_ctrl: got %h expected %h", rd, CTRL_RST);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_w1c_collision();
        test_irq();
        test_flush_errors();
        test_reset_mid();
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
